// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A - B - Bin, LSB first, one bit per clock.
// A single full-subtractor cell feeds a borrow flip-flop. A start/busy/done
// handshake issues operations. Results update only when the operation ends.
// Optional feature macro: SERIAL_SUB_OVF_EN adds the signed overflow output Ovf.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             Zero,
`ifdef SERIAL_SUB_OVF_EN
  output logic             Ovf,
`endif
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb, sr;
  logic             borrow;
  logic [CW-1:0]    count;
  logic             last_bit;
  logic             bit_a, bit_b, bit_d, borrow_nxt;

`ifdef SERIAL_SUB_OVF_EN
  // Operand sign bits are shifted out of sa/sb, so keep copies for Ovf.
  logic             a_msb, b_msb;
`endif

  assign last_bit = (count == CW'(WIDTH - 1));

  // Full-subtractor cell on the current LSBs and the stored borrow.
  always_comb begin
    bit_a      = sa[0];
    bit_b      = sb[0];
    bit_d      = bit_a ^ bit_b ^ borrow;
    borrow_nxt = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & borrow);
  end

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs.
  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, serial shifting and the result load.
  // NOTE: these are plain registers, not memories, so all of them are reset;
  // Zero resets to 1 to stay consistent with Diff = 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa     <= '0;
      sb     <= '0;
      sr     <= '0;
      borrow <= 1'b0;
      count  <= '0;
      Diff   <= '0;
      Bout   <= 1'b0;
      Zero   <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      Ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa     <= A;
            sb     <= B;
            borrow <= Bin;
            count  <= '0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb  <= A[WIDTH-1];
            b_msb  <= B[WIDTH-1];
`endif
          end
        end
        SHIFT: begin
          sr     <= {bit_d, sr[WIDTH-1:1]};
          sa     <= {1'b0, sa[WIDTH-1:1]};
          sb     <= {1'b0, sb[WIDTH-1:1]};
          borrow <= borrow_nxt;
          count  <= count + 1'b1;
        end
        DONE: begin
          Diff <= sr;
          Bout <= borrow;
          Zero <= (sr == '0);
`ifdef SERIAL_SUB_OVF_EN
          Ovf  <= (a_msb ^ b_msb) & (sr[WIDTH-1] ^ a_msb);
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench for serial_subtractor (WIDTH=8).
// The driver pushes expected results computed with plain integer arithmetic;
// a monitor pops and compares whenever the DUT pulses done.
module tb_serial_subtractor;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         zero;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         bin;
  logic [W-1:0] diff;
  logic         bout, zero, busy, done;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  exp_t         q[$];
  int           n_checks   = 0;
  int           n_fail     = 0;
  int           ops_issued = 0;
  int           done_count = 0;
  logic [W-1:0] last_diff  = '0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (a),
    .B     (b),
    .Bin   (bin),
    .Diff  (diff),
    .Bout  (bout),
    .Zero  (zero),
`ifdef SERIAL_SUB_OVF_EN
    .Ovf   (ovf),
`endif
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: unsigned modular subtraction, borrow as a plain comparison,
  // overflow from the operand/result sign bits.
  function automatic exp_t model(input int av, input int bv, input int bn);
    exp_t e;
    int   raw;
    raw    = av - bv - bn;
    e.diff = W'(raw & ((1 << W) - 1));
    e.bout = (av < bv + bn);
    e.zero = (e.diff == 0);
    e.ovf  = (((av >> (W-1)) & 1) != ((bv >> (W-1)) & 1)) &&
             (((int'(e.diff) >> (W-1)) & 1) != ((av >> (W-1)) & 1));
    return e;
  endfunction

  // Issue one operation and check handshake timing; optionally pulse start
  // again mid-operation with different held inputs.
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic bn, input bit extra_starts);
    int   n;
    bit   seen;
    exp_t e;
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    a = av; b = bv; bin = bn; start = 1'b1;
    e = model(av, bv, bn);
    q.push_back(e);
    ops_issued++;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (extra_starts) begin
      a = '1; b = '1; bin = 1'b0;
    end else begin
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    end
    n = 0;
    seen = 0;
    while (n < 40 && !seen) begin
      @(negedge clk);
      n++;
      start = (extra_starts && (n == 3 || n == 6)) ? 1'b1 : 1'b0;
      check("busy_during_op", busy, 1);
      if (n <= W) check("diff_hold", diff, last_diff);
      if (done) seen = 1;
    end
    start = 1'b0;
    check("done_latency", n, W + 1);
    last_diff = e.diff;
  endtask

  // Monitor: results are registered on the edge that ends the done cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        done_count++;
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          check("diff", diff, e.diff);
          check("bout", bout, e.bout);
          check("zero", zero, e.zero);
`ifdef SERIAL_SUB_OVF_EN
          check("ovf", ovf, e.ovf);
`endif
        end
      end
    end
  end

  initial begin
    rst_n = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_diff", diff, 0);
    check("rst_bout", bout, 0);
    check("rst_zero", zero, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
`ifdef SERIAL_SUB_OVF_EN
    check("rst_ovf", ovf, 0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed cases, including borrow-chain and zero edges.
    do_op(8'h35, 8'h12, 1'b0, 0);
    do_op(8'h12, 8'h35, 1'b0, 0);
    do_op(8'h00, 8'h00, 1'b1, 0);
    do_op(8'h5A, 8'h5A, 1'b0, 0);
    do_op(8'h80, 8'h01, 1'b0, 0);
    do_op(8'h7F, 8'hFF, 1'b0, 0);
    do_op(8'hFF, 8'h00, 1'b0, 0);
    do_op(8'h00, 8'hFF, 1'b1, 0);

    // Starts while busy must be ignored.
    do_op(8'h10, 8'h01, 1'b0, 1);

    // Abort mid-operation with reset.
    @(negedge clk);
    a = 8'h33; b = 8'h11; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_diff", diff, 0);
    check("abort_zero", zero, 1);
    check("abort_bout", bout, 0);
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
    end
    rst_n = 1'b1;
    last_diff = '0;
    do_op(8'hC3, 8'h41, 1'b1, 0);

    // Randomized back-to-back operations.
    for (int i = 0; i < 30; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), 0);
    end

    repeat (4) @(negedge clk);
    check("queue_empty", q.size(), 0);
    check("done_count", done_count, ops_issued);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
